draw_sprite: RTL and testbench

//  Parametrised sprite overlay on the vga_if stream: replaces pixels inside a
//  W x H window at (xpos,ypos) with pixels read from a synchronous image ROM.

---
 rtl/draw_sprite.sv | 155 +++++++++++++++
 tb/tb_draw_sprite.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sprite.sv
// Sprite overlay: replaces pixels inside a W x H window with image ROM pixels, with optional colour-key transparency.
// Latency: every output field is delayed by exactly LAT = ROM_LAT+2 clocks. Throughput is one pixel per clock.
// Backpressure: none. This is a free-running pixel stream, so every input sample produces one output sample.
module draw_sprite #(
  parameter int          W         = 100,
  parameter int          H         = 100,
  parameter int          ROM_LAT   = 1,
  parameter int          ADDR_W    = 14,
  parameter int          KEY_EN    = 1,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  // upstream stream
  input  logic [10:0]       vga_in_hcount,
  input  logic [10:0]       vga_in_vcount,
  input  logic              vga_in_hsync,
  input  logic              vga_in_vsync,
  input  logic              vga_in_hblnk,
  input  logic              vga_in_vblnk,
  input  logic [11:0]       vga_in_rgb,
  // downstream stream
  output logic [10:0]       vga_out_hcount,
  output logic [10:0]       vga_out_vcount,
  output logic              vga_out_hsync,
  output logic              vga_out_vsync,
  output logic              vga_out_hblnk,
  output logic              vga_out_vblnk,
  output logic [11:0]       vga_out_rgb,
  // sprite placement
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              enable,
  // image ROM
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data
);

  localparam int DEPTH = ROM_LAT + 1;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t              vga_cur;
  vga_t              pipe [DEPTH];
  logic [DEPTH-1:0]  hit_pipe;
  vga_t              out_q;

  logic [11:0]       xpos_q;
  logic [11:0]       ypos_q;
  logic              en_q;
  logic              vblnk_prev;

  logic              hit;
  logic [ADDR_W-1:0] addr_c;
  logic              show_rom;

  assign vga_cur = '{hcount: vga_in_hcount, vcount: vga_in_vcount,
                     hsync: vga_in_hsync, vsync: vga_in_vsync,
                     hblnk: vga_in_hblnk, vblnk: vga_in_vblnk,
                     rgb: vga_in_rgb};

  // Sample the placement once per frame on the rising edge of vblnk, so a frame is never drawn with mixed positions.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q     <= '0;
      ypos_q     <= '0;
      en_q       <= 1'b0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vga_in_vblnk;
      if (vga_in_vblnk && !vblnk_prev) begin
        xpos_q <= xpos;
        ypos_q <= ypos;
        en_q   <= enable;
      end
    end
  end

  // Window test and ROM address. The window edges are computed in 13 bits, so a window that runs past the counters clips instead of wrapping.
  always_comb begin
    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic [12:0] x_end;
    logic [12:0] y_end;
    logic [10:0] row_off;
    logic [10:0] col_off;
    h_ext   = {2'b00, vga_in_hcount};
    v_ext   = {2'b00, vga_in_vcount};
    x_end   = {1'b0, xpos_q} + 13'(W);
    y_end   = {1'b0, ypos_q} + 13'(H);
    hit     = en_q
              && (h_ext >= {1'b0, xpos_q}) && (h_ext < x_end)
              && (v_ext >= {1'b0, ypos_q}) && (v_ext < y_end);
    // Inside the window both offsets are non-negative and smaller than W and H.
    row_off = vga_in_vcount - ypos_q[10:0];
    col_off = vga_in_hcount - xpos_q[10:0];
    addr_c  = '0;
    if (hit) begin
      addr_c = ADDR_W'(row_off) * ADDR_W'(W) + ADDR_W'(col_off);
    end
  end

  // Registered ROM address plus a timing/hit delay line that keeps the stream aligned with rom_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      hit_pipe <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      rom_addr    <= addr_c;
      hit_pipe[0] <= hit;
      pipe[0]     <= vga_cur;
      for (int i = 1; i < DEPTH; i++) begin
        hit_pipe[i] <= hit_pipe[i-1];
        pipe[i]     <= pipe[i-1];
      end
    end
  end

  // A ROM pixel wins only inside the window, outside blanking, and when it is not the transparent key colour.
  always_comb begin
    show_rom = hit_pipe[DEPTH-1]
               && !((KEY_EN != 0) && (rom_data == KEY_COLOR))
               && !(pipe[DEPTH-1].hblnk || pipe[DEPTH-1].vblnk);
  end

  // Output register. Every timing field passes through at the same latency as rgb.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q     <= pipe[DEPTH-1];
      out_q.rgb <= show_rom ? rom_data : pipe[DEPTH-1].rgb;
    end
  end

  assign vga_out_hcount = out_q.hcount;
  assign vga_out_vcount = out_q.vcount;
  assign vga_out_hsync  = out_q.hsync;
  assign vga_out_vsync  = out_q.vsync;
  assign vga_out_hblnk  = out_q.hblnk;
  assign vga_out_vblnk  = out_q.vblnk;
  assign vga_out_rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprite.sv
// Testbench for draw_sprite on a reduced video raster, checked against a behavioural per-pixel reference model.
// Latency: output is compared against the model entry produced LAT cycles earlier. The ROM is modelled with ROM_LAT cycles of delay.
// Backpressure: none. One pixel is driven per clock.
module tb_draw_sprite;

  localparam int          W        = 10;
  localparam int          H        = 6;
  localparam int          ROM_LAT  = 2;
  localparam int          ADDR_W   = 7;
  localparam int          KEY_EN   = 1;
  localparam logic [11:0] KEY      = 12'hF0F;
  localparam int          LAT      = ROM_LAT + 2;
  localparam int          HT = 64, HA = 48, HS0 = 52, HS1 = 56;
  localparam int          VT = 40, VA = 30, VS0 = 33, VS1 = 35;
  localparam int          FRAME = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0]       in_h = '0, in_v = '0;
  logic              in_hs = 1'b0, in_vs = 1'b0, in_hb = 1'b0, in_vb = 1'b0;
  logic [11:0]       in_rgb = '0;
  logic [10:0]       out_h, out_v;
  logic              out_hs, out_vs, out_hb, out_vb;
  logic [11:0]       out_rgb;
  logic [11:0]       xpos = '0, ypos = '0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data;

  draw_sprite #(
    .W(W), .H(H), .ROM_LAT(ROM_LAT), .ADDR_W(ADDR_W),
    .KEY_EN(KEY_EN), .KEY_COLOR(KEY)
  ) dut (
    .clk(clk), .rst(rst),
    .vga_in_hcount(in_h), .vga_in_vcount(in_v),
    .vga_in_hsync(in_hs), .vga_in_vsync(in_vs),
    .vga_in_hblnk(in_hb), .vga_in_vblnk(in_vb), .vga_in_rgb(in_rgb),
    .vga_out_hcount(out_h), .vga_out_vcount(out_v),
    .vga_out_hsync(out_hs), .vga_out_vsync(out_vs),
    .vga_out_hblnk(out_hb), .vga_out_vblnk(out_vb), .vga_out_rgb(out_rgb),
    .xpos(xpos), .ypos(ypos), .enable(enable),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  // Synchronous image ROM with ROM_LAT cycles from address to data.
  logic [11:0] rom [0:(1<<ADDR_W)-1];
  logic [11:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom[rom_addr];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  int checks = 0;
  int errors = 0;
  int drawn  = 0;

  // Reference model state
  int                mxq = 0, myq = 0;
  bit                meq = 1'b0, mprev = 1'b0;
  pix_t              expq[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  int                gh = 0, gv = 0;

  task automatic tick();
    pix_t        e;
    pix_t        got;
    bit          hit;
    int          a;
    logic [11:0] px;
    in_h   = 11'(gh);
    in_v   = 11'(gv);
    in_hb  = (gh >= HA);
    in_vb  = (gv >= VA);
    in_hs  = (gh >= HS0) && (gh < HS1);
    in_vs  = (gv >= VS0) && (gv < VS1);
    in_rgb = 12'($urandom);
    #1;
    got = {out_h, out_v, out_hs, out_vs, out_hb, out_vb, out_rgb};
    e   = expq.pop_front();
    checks++;
    assert ({got.h, got.v, got.hs, got.vs, got.hb, got.vb} === {e.h, e.v, e.hs, e.vs, e.hb, e.vb})
      else begin errors++; $error("FAIL timing: got %h required %h", got[38:12], e[38:12]); end
    checks++;
    assert (got.rgb === e.rgb)
      else begin errors++; $error("FAIL rgb at h=%0d v=%0d: got %h required %h", e.h, e.v, got.rgb, e.rgb); end
    checks++;
    assert (rom_addr === exp_addr)
      else begin errors++; $error("FAIL rom_addr: got %0d required %0d", rom_addr, exp_addr); end
    checks++;
    assert (int'(rom_addr) < W * H)
      else begin errors++; $error("FAIL rom_addr_range: got %0d required < %0d", rom_addr, W * H); end

    // Expected result for the pixel being driven in this cycle
    hit = meq && (gh >= mxq) && (gh < mxq + W) && (gv >= myq) && (gv < myq + H);
    a   = hit ? (gv - myq) * W + (gh - mxq) : 0;
    px  = rom[a];
    e   = {in_h, in_v, in_hs, in_vs, in_hb, in_vb, in_rgb};
    if (hit && !(in_hb || in_vb) && !(KEY_EN != 0 && px == KEY)) begin
      e.rgb = px;
      if (!rst) drawn++;
    end
    exp_addr = rst ? '0 : ADDR_W'(a);
    if (rst) begin
      foreach (expq[i]) expq[i] = '0;
      e     = '0;
      mxq   = 0;
      myq   = 0;
      meq   = 1'b0;
      mprev = 1'b0;
    end else begin
      if (in_vb && !mprev) begin
        mxq = int'(xpos);
        myq = int'(ypos);
        meq = enable;
      end
      mprev = in_vb;
    end
    expq.push_back(e);

    @(posedge clk);
    #1;
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv = (gv + 1 == VT) ? 0 : gv + 1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until_line(input int line);
    int budget;
    budget = 2 * FRAME;
    while (!(gv == line && gh == 0) && budget > 0) begin
      tick();
      budget--;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      rom[i] = 12'($urandom);
      if (i % 7 == 3) rom[i] = KEY;
    end
    rom[0] = KEY;
    for (int i = 0; i < LAT; i++) expq.push_back('0);

    // Reset: registers clear, ROM pipe fills with defined data
    repeat (ROM_LAT + 2) @(posedge clk);
    #1;
    run(4);
    rst = 1'b0;

    // Pass-through while the latched enable is 0
    xpos = 12'd5; ypos = 12'd3; enable = 1'b0;
    run(FRAME + FRAME / 2);

    // Corner placement; ROM word 0 is the key colour
    xpos = 12'd0; ypos = 12'd0; enable = 1'b1;
    run(FRAME);

    // Random in-screen placements
    for (int k = 0; k < 4; k++) begin
      xpos = 12'($urandom_range(0, HA - W));
      ypos = 12'($urandom_range(0, VA - H));
      run(FRAME);
    end

    // Mid-frame position change takes effect at the next frame only
    xpos = 12'd10; ypos = 12'd5;
    run_until_line(2);
    run_until_line(15);
    xpos = 12'd30; ypos = 12'd20;
    run(2 * FRAME);

    // Clipping at the right/bottom edges, in blanking, and far past the counters
    xpos = 12'd42; ypos = 12'd27;
    run(FRAME);
    xpos = 12'd60; ypos = 12'd36;
    run(FRAME);
    xpos = 12'd4092; ypos = 12'd4094;
    run(FRAME);

    // Reset for 5 cycles mid-frame while a sprite is visible
    xpos = 12'd8; ypos = 12'd9;
    run(FRAME);
    run_until_line(12);
    run(5);
    rst = 1'b1;
    run(5);
    rst = 1'b0;
    run(2 * FRAME);

    // Disabled again: plain delay line
    enable = 1'b0;
    run(2 * FRAME);

    checks++;
    assert (drawn > 100)
      else begin errors++; $error("FAIL sprite_activity: got %0d drawn pixels required > 100", drawn); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
